// File: rtl/push_conditioner.sv
// Front-panel push-button conditioner: per-channel 2-flop sync, debounce,
// press pulse and hold-to-repeat pulse train. Channels are fully independent.
//
// state  | meaning
// IDLE   | debounced level low, waiting for an accepted press
// DELAY  | held, counting toward the first auto-repeat
// REPEAT | held, emitting auto-repeat pulses every REPEAT_PERIOD edges
module push_conditioner #(
   parameter int N_BTN           = 5,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 5000,
   parameter int REPEAT_PERIOD   = 1500
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [N_BTN-1:0] push_raw,
   input  logic             enable,
   output logic [N_BTN-1:0] push_level,
   output logic [N_BTN-1:0] push_pulse,
   output logic [N_BTN-1:0] push_repeat
);

   localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_ONE      = DB_W'(1);
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } chan_state_e;

   logic [N_BTN-1:0] sync_q1;
   logic [N_BTN-1:0] sync_q2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= push_raw;
         sync_q2 <= sync_q1;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      chan_state_e       state;
      chan_state_e       state_nxt;
      logic [DB_W-1:0]   db_cnt;
      logic [DB_W-1:0]   db_cnt_nxt;
      logic [HOLD_W-1:0] hold_cnt;
      logic [HOLD_W-1:0] hold_cnt_nxt;
      logic              level_q;
      logic              level_nxt;
      logic              pulse_q;
      logic              pulse_nxt;
      logic              repeat_q;
      logic              repeat_nxt;

      // Any disagreement that returns early clears the count.
      always_comb begin
         db_cnt_nxt = db_cnt;
         level_nxt  = level_q;
         if (sync_q2[i] == level_q) begin
            db_cnt_nxt = '0;
         end else if (db_cnt == DB_LAST) begin
            level_nxt  = sync_q2[i];
            db_cnt_nxt = '0;
         end else begin
            db_cnt_nxt = db_cnt + DB_ONE;
         end
      end

      // FSM follows the level being registered this edge, so press and
      // release are seen in the same cycle push_level changes.
      always_comb begin
         state_nxt    = state;
         hold_cnt_nxt = hold_cnt;
         if (!level_nxt) begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end else if (!enable) begin
            state_nxt    = DELAY;
            hold_cnt_nxt = '0;
         end else begin
            case (state)
               IDLE: begin
                  state_nxt    = DELAY;
                  hold_cnt_nxt = '0;
               end
               DELAY: begin
                  if (hold_cnt == DELAY_LAST) begin
                     state_nxt    = REPEAT;
                     hold_cnt_nxt = '0;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HOLD_ONE;
                  end
               end
               REPEAT: begin
                  if (hold_cnt == PERIOD_LAST) begin
                     hold_cnt_nxt = '0;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HOLD_ONE;
                  end
               end
               default: begin
                  state_nxt    = IDLE;
                  hold_cnt_nxt = '0;
               end
            endcase
         end
      end

      always_comb begin
         pulse_nxt  = 1'b0;
         repeat_nxt = 1'b0;
         if (enable && level_nxt) begin
            case (state)
               IDLE: begin
                  pulse_nxt  = 1'b1;
                  repeat_nxt = 1'b1;
               end
               DELAY:   repeat_nxt = (hold_cnt == DELAY_LAST);
               REPEAT:  repeat_nxt = (hold_cnt == PERIOD_LAST);
               default: repeat_nxt = 1'b0;
            endcase
         end
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            state    <= IDLE;
            db_cnt   <= '0;
            hold_cnt <= '0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            repeat_q <= 1'b0;
         end else begin
            state    <= state_nxt;
            db_cnt   <= db_cnt_nxt;
            hold_cnt <= hold_cnt_nxt;
            level_q  <= level_nxt;
            pulse_q  <= pulse_nxt;
            repeat_q <= repeat_nxt;
         end
      end

      assign push_level[i]  = level_q;
      assign push_pulse[i]  = pulse_q;
      assign push_repeat[i] = repeat_q;
   end

endmodule

// File: tb/tb_push_conditioner.sv
// Directed bench for push_conditioner: one instance at DEBOUNCE=16 for the
// reset/stability case, one at DEBOUNCE=4, DELAY=10, PERIOD=3 for the rest.
module tb_push_conditioner;

   logic       clk;
   logic       resetn;
   logic [4:0] raw_a, raw_b;
   logic       en_a, en_b;
   logic [4:0] lvl_a, pul_a, rep_a;
   logic [4:0] lvl_b, pul_b, rep_b;
   int         n_cmp;
   int         n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   push_conditioner #(
      .N_BTN(5), .DEBOUNCE_CYCLES(16), .REPEAT_DELAY(5000), .REPEAT_PERIOD(1500)
   ) dut_a (
      .clk(clk), .resetn(resetn), .push_raw(raw_a), .enable(en_a),
      .push_level(lvl_a), .push_pulse(pul_a), .push_repeat(rep_a)
   );

   push_conditioner #(
      .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_b (
      .clk(clk), .resetn(resetn), .push_raw(raw_b), .enable(en_b),
      .push_level(lvl_b), .push_pulse(pul_b), .push_repeat(rep_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_b(input string tag, input logic [4:0] l, input logic [4:0] p,
                        input logic [4:0] r);
      chk({tag, ".level"},  lvl_b, l);
      chk({tag, ".pulse"},  pul_b, p);
      chk({tag, ".repeat"}, rep_b, r);
   endtask

   initial begin
      logic [4:0] rexp;
      logic [4:0] lexp;
      n_cmp  = 0;
      n_err  = 0;
      resetn = 1'b0;
      raw_a  = 5'b11111;
      raw_b  = 5'b00000;
      en_a   = 1'b1;
      en_b   = 1'b1;

      // Reset and stability
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst.level", lvl_a, 5'b0);
         chk("rst.pulse", pul_a, 5'b0);
         chk("rst.repeat", rep_a, 5'b0);
      end
      resetn = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         chk("stab.level", lvl_a, 5'b0);
         chk("stab.pulse", pul_a, 5'b0);
      end
      tick();
      chk("stab.e18.level", lvl_a, 5'b11111);
      chk("stab.e18.pulse", pul_a, 5'b11111);
      chk("stab.e18.repeat", rep_a, 5'b11111);
      tick();
      chk("stab.e19.level", lvl_a, 5'b11111);
      chk("stab.e19.pulse", pul_a, 5'b0);
      chk("stab.e19.repeat", rep_a, 5'b0);
      raw_a = 5'b0;
      chk_b("idle_b", 5'b0, 5'b0, 5'b0);

      // Bounce rejection on channel 0
      raw_b = 5'b00001;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_b("glitch.hi", 5'b0, 5'b0, 5'b0);
      end
      raw_b = 5'b00000;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk_b("glitch.lo", 5'b0, 5'b0, 5'b0);
      end
      raw_b = 5'b00001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_b("bounce.wait", 5'b0, 5'b0, 5'b0);
      end
      tick();
      chk_b("bounce.press", 5'b00001, 5'b00001, 5'b00001);
      raw_b = 5'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         lexp = (k < 6) ? 5'b00001 : 5'b0;
         chk_b("bounce.after", lexp, 5'b0, 5'b0);
      end

      // Auto-repeat on channel 1, released after P+25
      raw_b = 5'b00010;
      for (int k = 1; k <= 5; k++) tick();
      tick();
      chk_b("rep.P", 5'b00010, 5'b00010, 5'b00010);
      for (int k = 1; k <= 31; k++) begin
         tick();
         rexp = (k >= 10 && k < 31 && ((k - 10) % 3) == 0) ? 5'b00010 : 5'b0;
         lexp = (k < 31) ? 5'b00010 : 5'b0;
         chk_b("rep.hold", lexp, 5'b0, rexp);
         if (k == 25) raw_b = 5'b0;
      end
      for (int k = 0; k < 4; k++) tick();

      // Release mid-delay on channel 2, then re-press
      raw_b = 5'b00100;
      for (int k = 1; k <= 5; k++) tick();
      tick();
      chk_b("rel.P", 5'b00100, 5'b00100, 5'b00100);
      raw_b = 5'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         lexp = (k < 6) ? 5'b00100 : 5'b0;
         chk_b("rel.after", lexp, 5'b0, 5'b0);
      end
      raw_b = 5'b00100;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_b("rel.repress.wait", 5'b0, 5'b0, 5'b0);
      end
      tick();
      chk_b("rel.repress", 5'b00100, 5'b00100, 5'b00100);
      raw_b = 5'b0;
      for (int k = 0; k < 8; k++) tick();
      chk_b("rel.done", 5'b0, 5'b0, 5'b0);

      // Enable gating on channel 4
      en_b  = 1'b0;
      raw_b = 5'b10000;
      for (int k = 1; k <= 10; k++) begin
         tick();
         lexp = (k >= 6) ? 5'b10000 : 5'b0;
         chk_b("en.off", lexp, 5'b0, 5'b0);
      end
      en_b = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         rexp = (k == 10 || k == 13) ? 5'b10000 : 5'b0;
         lexp = (k < 16) ? 5'b10000 : 5'b0;
         chk_b("en.on", lexp, 5'b0, rexp);
         if (k == 10) raw_b = 5'b0;
      end
      for (int k = 0; k < 4; k++) tick();

      // Async reset mid-repeat on channel 3
      raw_b = 5'b01000;
      for (int k = 1; k <= 5; k++) tick();
      tick();
      chk_b("ar.P", 5'b01000, 5'b01000, 5'b01000);
      for (int k = 1; k <= 13; k++) begin
         tick();
         rexp = (k == 10 || k == 13) ? 5'b01000 : 5'b0;
         chk_b("ar.hold", 5'b01000, 5'b0, rexp);
      end
      #1;
      resetn = 1'b0;
      #1;
      chk_b("ar.async", 5'b0, 5'b0, 5'b0);
      tick();
      tick();
      chk_b("ar.inreset", 5'b0, 5'b0, 5'b0);
      resetn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_b("ar.resync", 5'b0, 5'b0, 5'b0);
      end
      tick();
      chk_b("ar.repress", 5'b01000, 5'b01000, 5'b01000);
      raw_b = 5'b0;
      for (int k = 0; k < 8; k++) tick();
      chk_b("ar.done", 5'b0, 5'b0, 5'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/push_conditioner.md
Name: push_conditioner

Overview:
- Upstream input stage for the five front-panel push buttons (u, d, l, r, m). It feeds the time-set, alarm-set, stopwatch and alarm/minigame services.
- Synchronizes each raw button to the system clock and debounces it.
- Produces a clean level, a one-cycle press pulse, and a hold-to-repeat pulse train, so a held up/down button steps digits at a steady rate.
- Buttons are processed fully independently, one identical channel per bit.

Parameters:
- N_BTN, 5, number of button channels; bit order u,d,l,r,m = 0..4.
- DEBOUNCE_CYCLES, 16, consecutive cycles of disagreement with the debounced level needed to accept a change; must be >= 1.
- REPEAT_DELAY, 5000, clock edges from the press pulse to the first auto-repeat pulse; must be >= 1.
- REPEAT_PERIOD, 1500, clock edges between successive auto-repeat pulses; must be >= 1.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- resetn, input, 1, asynchronous active-low reset.
- push_raw, input, N_BTN, raw asynchronous button levels; 1 = pressed.
- enable, input, 1, 1 = pulse outputs active; 0 = pulse outputs suppressed.
- push_level, output, N_BTN, debounced button level.
- push_pulse, output, N_BTN, one-cycle pulse on each accepted press.
- push_repeat, output, N_BTN, pulse on press, then auto-repeat pulses while held.

Behaviour:
- Reset: while resetn = 0, all flops clear asynchronously: sync stages, debounce counters, hold counters, channel state = IDLE, push_level = 0, push_pulse = 0, push_repeat = 0.
- Reset release: no output may pulse until a full synchronize + debounce sequence completes. A button already held at release is treated as a new press.
- Synchronizer: 2-flop chain per channel. s = second-stage output.
- Debounce, per channel (counter width clog2(DEBOUNCE_CYCLES)):
  - If s == push_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: push_level <= s, counter <= 0.
  - Else: counter <= counter + 1.
- Debounce latency: push_level changes on the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples the new raw value. Any bounce that returns before then resets the count; push_level does not change.
- Debounce runs regardless of enable.
- Channel FSM states, all transitions on rising edges:
  - IDLE (push_level = 0): on the edge where push_level rises, push_pulse = 1 and push_repeat = 1 for that cycle only (registered together with push_level); hold counter <= 0; go to DELAY.
  - DELAY: hold counter increments each edge. When hold counter == REPEAT_DELAY-1: push_repeat = 1 for one cycle, hold counter <= 0, go to REPEAT.
  - REPEAT: hold counter increments each edge. When hold counter == REPEAT_PERIOD-1: push_repeat = 1 for one cycle, hold counter <= 0, stay in REPEAT.
  - Release: from DELAY or REPEAT, when push_level falls, go to IDLE and clear the hold counter. No pulse is emitted on release.
- Repeat timing: for a press pulse at edge P, repeat pulses occur at P+REPEAT_DELAY, then at P+REPEAT_DELAY+k*REPEAT_PERIOD for k >= 1.
- Hold counter width: clog2 of max(REPEAT_DELAY, REPEAT_PERIOD).
- enable = 0:
  - push_pulse and push_repeat are forced to 0.
  - The hold counter is held at 0 and state is forced to DELAY if the button is held, IDLE otherwise.
  - A press accepted while disabled produces no pulse, ever.
  - When enable returns with the button still held, the first repeat pulse comes a full REPEAT_DELAY edges later.
- Simultaneous presses: each channel is independent. Several bits may pulse in the same cycle. No priority or masking between channels.
- All outputs are registered. There are no combinational paths from push_raw or enable to any output.

Test Plan:
- Reset and stability: resetn = 0 for 3 cycles with push_raw = 5'b11111, then release. Required: all outputs 0 during reset. push_level = 5'b11111 on the 18th edge after release (DEBOUNCE_CYCLES = 16). push_pulse = push_repeat = 5'b11111 for exactly that one cycle.
- Bounce rejection (DEBOUNCE_CYCLES = 4): push_raw[0] high for 3 edges, low for 2, then high steady. Required: no change during the glitch. push_level[0] rises on the 6th edge after the steady high begins. Exactly one push_pulse[0].
- Auto-repeat (DEBOUNCE = 4, DELAY = 10, PERIOD = 3): hold push_raw[1] for 25 edges after the press pulse at edge P. Required: push_repeat[1] high at P, P+10, P+13, P+16, P+19, P+22, P+25. push_pulse[1] high only at P.
- Release mid-delay: press push_raw[2], release after the press pulse, before P+10. Required: no repeat pulse. push_level[2] falls 6 edges after the release sample. A re-press produces a fresh push_pulse.
- Enable gating: enable = 0 during the press of push_raw[4], raised at edge E while still held. Required: no push_pulse[4] at all. First push_repeat[4] at E+10.
- Async reset mid-repeat: assert resetn = 0 while push_repeat[3] is in REPEAT. Required: all outputs 0 immediately, without waiting for a clock edge. After release with the button still held, a new press pulse follows after the full debounce sequence.
